bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter between the NUM_CORES riscv_core_single instances and the shared data memory port.

---
 rtl/riscv_bus_pkg.sv | 26 ++
 rtl/rr_priority_picker.sv | 47 ++++
 rtl/bus_arbiter_rr.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// ----------------------------------------------------------------------------
// riscv_bus_pkg
//   Shared types and defaults for the multi-core data-bus arbitration logic.
//   - arb_state_t   : arbiter FSM states (IDLE -> ACCESS -> DONE)
//   - BUS_ADDR_W    : default bus address width
//   - BUS_DATA_W    : default bus data width
//   - NUM_CORES_DEF : default number of requesting cores
//   - idx_w()       : width of an index into n requesters (min 1 bit)
// ----------------------------------------------------------------------------
package riscv_bus_pkg;

   localparam int BUS_ADDR_W    = 32;
   localparam int BUS_DATA_W    = 32;
   localparam int NUM_CORES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker: returns the first set request bit
//   found when searching ptr, ptr+1, ... wrapping modulo N.
//   Ports:
//     req    in  N      request vector, bit i = requester i
//     ptr    in  IDX_W  highest-priority requester index this round (< N)
//     any    out 1      at least one request is set
//     winner out IDX_W  index of the selected requester (0 when !any)
// ----------------------------------------------------------------------------
module rr_priority_picker
   import riscv_bus_pkg::*;
#(
   parameter int N     = NUM_CORES_DEF,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] winner
);

   logic [2*N-1:0]   req_dbl;
   logic [N-1:0]     req_rot;
   logic [IDX_W-1:0] ffs_idx;
   logic [IDX_W:0]   sum;

   always_comb begin
      // Rotate right by ptr through a doubled copy so any N (not only
      // powers of two) wraps correctly; bit 0 of req_rot is requester ptr.
      req_dbl = {req, req};
      req_rot = N'(req_dbl >> ptr);
      any     = |req;

      // Find-first-set: walk downwards so the lowest set bit wins.
      ffs_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) ffs_idx = IDX_W'(i);
      end

      // Un-rotate: winner = (ffs_idx + ptr) mod N.
      sum = {1'b0, ffs_idx} + {1'b0, ptr};
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      winner = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// ----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter between NUM_CORES cores and one shared data-memory
//   port. One transaction at a time is latched and presented on a
//   valid/ready memory interface; completion (or timeout) is reported back
//   to the owning core with a one-cycle bus_grant pulse.
//   Ports:
//     clk        in   1                 rising-edge clock
//     reset      in   1                 async active-low reset (0 = reset)
//     bus_req    in   NUM_CORES         per-core request
//     bus_we     in   NUM_CORES         per-core write enable
//     bus_addr   in   NUM_CORES*ADDR_W  core i at [i*ADDR_W +: ADDR_W]
//     bus_wdata  in   NUM_CORES*DATA_W  core i at [i*DATA_W +: DATA_W]
//     bus_grant  out  NUM_CORES         one-hot pulse: core's transaction done
//     bus_rdata  out  DATA_W            data of last completed read
//     bus_err    out  1                 pulses with bus_grant on timeout
//     mem_valid  out  1                 memory request valid
//     mem_we     out  1                 memory write enable
//     mem_addr   out  ADDR_W            memory address
//     mem_wdata  out  DATA_W            memory write data
//     mem_ready  in   1                 memory completed the request
//     mem_rdata  in   DATA_W            memory read data
// ----------------------------------------------------------------------------
module bus_arbiter_rr
   import riscv_bus_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int ADDR_W    = BUS_ADDR_W,
   parameter int DATA_W    = BUS_DATA_W,
   parameter int TIMEOUT   = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        bus_req,
   input  logic [NUM_CORES-1:0]        bus_we,
   input  logic [NUM_CORES*ADDR_W-1:0] bus_addr,
   input  logic [NUM_CORES*DATA_W-1:0] bus_wdata,
   output logic [NUM_CORES-1:0]        bus_grant,
   output logic [DATA_W-1:0]           bus_rdata,
   output logic                        bus_err,
   output logic                        mem_valid,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic                        mem_ready,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam int IDX_W = idx_w(NUM_CORES);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t       state_q,   state_d;
   logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
   logic [IDX_W-1:0] winner_q,  winner_d;
   logic             we_q,      we_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_priority_picker #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (bus_req),
      .ptr    (rr_ptr_q),
      .any    (pick_any),
      .winner (pick_idx)
   );

   // Select the winning core's live request fields; they are only used at
   // the IDLE -> ACCESS edge, after which the latched copies drive memory.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_we    = bus_we[i];
            sel_addr  = bus_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      winner_d  = winner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bus_err_d = bus_err_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               winner_d  = pick_idx;
               we_d      = sel_we;
               addr_d    = sel_addr;
               wdata_d   = sel_wdata;
               cnt_d     = '0;
               bus_err_d = 1'b0;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               if (!we_q) rdata_d = mem_rdata;
               bus_err_d = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // TIMEOUT full ACCESS cycles without ready: abort, keep rdata.
               bus_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            // Move priority past the core just served so it is last next round.
            rr_ptr_d = (winner_q == IDX_W'(NUM_CORES - 1)) ? '0 : winner_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         winner_q  <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         winner_q  <= winner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         cnt_q     <= cnt_d;
      end
   end

   // All outputs decode registered state only; reset forces state to IDLE,
   // so mem_valid and bus_grant drop as soon as reset asserts.
   assign mem_valid = (state_q == ACCESS);
   assign mem_we    = mem_valid & we_q;
   assign mem_addr  = mem_valid ? addr_q  : '0;
   assign mem_wdata = mem_valid ? wdata_q : '0;

   always_comb begin
      bus_grant = '0;
      if (state_q == DONE) bus_grant[winner_q] = 1'b1;
   end

   assign bus_err   = (state_q == DONE) & bus_err_q;
   assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Self-checking bench for bus_arbiter_rr. Inputs change and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic              clk;
   logic              reset;
   logic [N-1:0]      bus_req;
   logic [N-1:0]      bus_we;
   logic [N*AW-1:0]   bus_addr;
   logic [N*DW-1:0]   bus_wdata;
   logic [N-1:0]      bus_grant;
   logic [DW-1:0]     bus_rdata;
   logic              bus_err;
   logic              mem_valid;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ready;
   logic [DW-1:0]     mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   bus_arbiter_rr #(
      .NUM_CORES (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_grant (bus_grant),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_core(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      bus_we[i]              = we;
      bus_addr[i*AW +: AW]   = a;
      bus_wdata[i*DW +: DW]  = d;
   endtask

   // Leaves the DUT in IDLE at a falling edge with reset just released.
   task automatic apply_reset();
      reset     = 1'b0;
      bus_req   = '0;
      bus_we    = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      bus_req   = '1;
      bus_we    = '1;
      bus_addr  = '1;
      bus_wdata = '1;
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_valid, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_mem: got v=%b we=%b a=%h d=%h want all 0", mem_valid, mem_we, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({bus_grant, bus_err} !== '0) begin
         n_err++;
         $display("FAIL reset_grant: got grant=%b err=%b want 0", bus_grant, bus_err);
      end
      n_cmp++;
      if (bus_rdata !== '0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h want 0", bus_rdata);
      end
      reset   = 1'b1;
      bus_req = '0;
      @(negedge clk);
      n_cmp++;
      if (mem_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got mem_valid=%b want 0", mem_valid);
      end
   endtask

   task automatic test_single();
      apply_reset();
      set_core(1, 1'b1, 32'h1004, 32'h5);
      bus_req   = 4'b0010;
      mem_ready = 1'b1;
      @(negedge clk);  // cycle 1
      n_cmp++;
      if ({mem_valid, mem_we, mem_addr, mem_wdata, bus_grant} !== {1'b1, 1'b1, 32'h1004, 32'h5, 4'b0000}) begin
         n_err++;
         $display("FAIL single_access: got v=%b we=%b a=%h d=%h g=%b want 1 1 1004 5 0000",
                  mem_valid, mem_we, mem_addr, mem_wdata, bus_grant);
      end
      bus_req = '0;   // requester withdraws mid-access
      set_core(1, 1'b0, 32'hBAD0, 32'hBAD1);
      @(negedge clk);  // cycle 2
      n_cmp++;
      if ({bus_grant, bus_err, mem_valid} !== {4'b0010, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL single_grant: got g=%b err=%b v=%b want 0010 0 0", bus_grant, bus_err, mem_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus_grant, mem_valid} !== '0) begin
         n_err++;
         $display("FAIL single_after: got g=%b v=%b want 0000 0", bus_grant, mem_valid);
      end
   endtask

   task automatic test_all_four();
      int t;
      logic [N-1:0] exp;
      apply_reset();
      for (int i = 0; i < N; i++) set_core(i, 1'b1, AW'(32'h100 * (i + 1)), DW'(i + 7));
      bus_req   = '1;
      mem_ready = 1'b1;
      t = 0;
      for (int g = 0; g < 5; g++) begin
         if (g > 0) begin
            @(negedge clk);
            t = 1;
         end
         while (bus_grant === '0 && t < 12) begin
            @(negedge clk);
            t++;
         end
         exp = N'(1) << (g % N);
         n_cmp++;
         if (bus_grant !== exp) begin
            n_err++;
            $display("FAIL all_four_order[%0d]: got %b want %b", g, bus_grant, exp);
         end
         n_cmp++;
         if (t !== ((g == 0) ? 2 : 3)) begin
            n_err++;
            $display("FAIL all_four_spacing[%0d]: got %0d cycles want %0d", g, t, (g == 0) ? 2 : 3);
         end
      end
   endtask

   task automatic test_fairness();
      int t;
      logic [N-1:0] exp, prev;
      apply_reset();
      set_core(0, 1'b0, 32'hA0, 32'h0);
      set_core(2, 1'b0, 32'hA2, 32'h0);
      bus_req   = 4'b0101;
      mem_ready = 1'b1;
      prev      = '0;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         t = 1;
         while (bus_grant === '0 && t < 12) begin
            @(negedge clk);
            t++;
         end
         exp = (g % 2 == 0) ? 4'b0001 : 4'b0100;
         n_cmp++;
         if (bus_grant !== exp || bus_grant === prev) begin
            n_err++;
            $display("FAIL fairness[%0d]: got %b want %b (prev %b)", g, bus_grant, exp, prev);
         end
         prev = bus_grant;
      end
   endtask

   task automatic test_stall();
      apply_reset();
      set_core(3, 1'b0, 32'h2000, 32'h0);
      bus_req   = 4'b1000;
      mem_ready = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         n_cmp++;
         if ({mem_valid, mem_we, mem_addr, bus_grant} !== {1'b1, 1'b0, 32'h2000, 4'b0000}) begin
            n_err++;
            $display("FAIL stall_stable[%0d]: got v=%b we=%b a=%h g=%b want 1 0 2000 0000",
                     k, mem_valid, mem_we, mem_addr, bus_grant);
         end
         if (k == 3) bus_req = '0;
         if (k == 6) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      mem_rdata = '0;
      n_cmp++;
      if ({bus_grant, bus_err, mem_valid} !== {4'b1000, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL stall_grant: got g=%b err=%b v=%b want 1000 0 0", bus_grant, bus_err, mem_valid);
      end
      n_cmp++;
      if (bus_rdata !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL stall_rdata: got %h want deadbeef", bus_rdata);
      end
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({bus_grant, mem_valid} !== '0 || bus_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL stall_single: got g=%b v=%b rd=%h want 0000 0 deadbeef", bus_grant, mem_valid, bus_rdata);
         end
      end
   endtask

   task automatic test_timeout();
      int t;
      apply_reset();
      set_core(1, 1'b1, 32'h44, 32'h99);
      bus_req   = 4'b0010;
      mem_ready = 1'b0;
      @(negedge clk);
      t = 0;
      while (mem_valid === 1'b1 && bus_grant === '0 && t < 40) begin
         t++;
         @(negedge clk);
      end
      n_cmp++;
      if (t !== TO) begin
         n_err++;
         $display("FAIL timeout_cycles: got %0d access cycles want %0d", t, TO);
      end
      n_cmp++;
      if ({bus_grant, bus_err, mem_valid} !== {4'b0010, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL timeout_grant: got g=%b err=%b v=%b want 0010 1 0", bus_grant, bus_err, mem_valid);
      end
      n_cmp++;
      if (bus_rdata !== '0) begin
         n_err++;
         $display("FAIL timeout_rdata: got %h want 0", bus_rdata);
      end
      // Pointer must now sit at core 2, so it beats the still-requesting core 1.
      set_core(2, 1'b1, 32'h48, 32'h1);
      bus_req   = 4'b0110;
      mem_ready = 1'b1;
      @(negedge clk);
      t = 1;
      while (bus_grant === '0 && t < 12) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if ({bus_grant, bus_err} !== {4'b0100, 1'b0}) begin
         n_err++;
         $display("FAIL timeout_ptr: got g=%b err=%b want 0100 0", bus_grant, bus_err);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      apply_reset();
      set_core(2, 1'b0, 32'h300, 32'h0);
      bus_req   = 4'b0100;
      mem_ready = 1'b1;
      t = 0;
      while (bus_grant === '0 && t < 12) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (bus_grant !== 4'b0100) begin
         n_err++;
         $display("FAIL rstmid_first: got %b want 0100", bus_grant);
      end
      mem_ready = 1'b0;
      @(negedge clk);
      t = 1;
      while (mem_valid !== 1'b1 && t < 12) begin
         @(negedge clk);
         t++;
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({mem_valid, bus_grant} !== '0) begin
         n_err++;
         $display("FAIL rstmid_async: got v=%b g=%b want 0 0000", mem_valid, bus_grant);
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_valid, bus_grant, bus_err} !== '0) begin
         n_err++;
         $display("FAIL rstmid_hold: got v=%b g=%b err=%b want 0", mem_valid, bus_grant, bus_err);
      end
      for (int i = 0; i < N; i++) set_core(i, 1'b1, AW'(32'h500 + i), DW'(i));
      bus_req   = '1;
      mem_ready = 1'b1;
      reset     = 1'b1;
      t = 0;
      while (bus_grant === '0 && t < 12) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (bus_grant !== 4'b0001) begin
         n_err++;
         $display("FAIL rstmid_after: got %b want 0001", bus_grant);
      end
   endtask

   // Randomised traffic against a transaction-level model: each cycle is
   // expected to be idle, a memory access for a known winner, or the
   // completion pulse; the winner comes from a plain round-robin search.
   task automatic test_random();
      int ph;          // 0 idle, 1 memory access, 2 completion pulse
      int ptr, cur, acc_n;
      bit exp_err, long_stall;
      logic          l_we;
      logic [AW-1:0] l_addr;
      logic [DW-1:0] l_wdata, rd_exp;
      logic [N-1:0]  g_exp;
      apply_reset();
      ph = 0; ptr = 0; cur = 0; acc_n = 0; exp_err = 1'b0; long_stall = 1'b0;
      l_we = 1'b0; l_addr = '0; l_wdata = '0; rd_exp = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         g_exp = '0;
         if (ph == 2) g_exp[cur] = 1'b1;
         n_cmp++;
         if (bus_grant !== g_exp) begin
            n_err++;
            $display("FAIL rnd_grant@%0d: got %b want %b", cyc, bus_grant, g_exp);
         end
         n_cmp++;
         if (mem_valid !== (ph == 1) || bus_err !== (ph == 2 && exp_err)) begin
            n_err++;
            $display("FAIL rnd_valid_err@%0d: got v=%b err=%b want %b %b", cyc, mem_valid, bus_err,
                     ph == 1, ph == 2 && exp_err);
         end
         n_cmp++;
         if (bus_rdata !== rd_exp) begin
            n_err++;
            $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, bus_rdata, rd_exp);
         end
         n_cmp++;
         if (ph == 1) begin
            if ({mem_we, mem_addr, mem_wdata} !== {l_we, l_addr, l_wdata}) begin
               n_err++;
               $display("FAIL rnd_mem@%0d: got we=%b a=%h d=%h want %b %h %h", cyc, mem_we, mem_addr,
                        mem_wdata, l_we, l_addr, l_wdata);
            end
         end else if ({mem_we, mem_addr, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL rnd_mem_idle@%0d: got we=%b a=%h d=%h want 0", cyc, mem_we, mem_addr, mem_wdata);
         end

         // Core behaviour: hold a request until its grant, occasionally give
         // up mid-access with scrambled fields, start new requests at random.
         if (ph == 2) begin
            bus_req[cur] = 1'b0;
            ptr = (cur + 1) % N;
         end
         if (ph == 1 && $urandom_range(0, 9) == 0) begin
            bus_req[cur] = 1'b0;
            set_core(cur, 1'($urandom), $urandom, $urandom);
         end
         for (int i = 0; i < N; i++) begin
            if (!bus_req[i] && $urandom_range(0, 3) == 0) begin
               set_core(i, 1'($urandom), $urandom, $urandom);
               bus_req[i] = 1'b1;
            end
         end
         mem_ready = 1'($urandom);
         mem_rdata = $urandom;

         case (ph)
            0: begin
               if (|bus_req) begin
                  for (int k = N - 1; k >= 0; k--) begin
                     if (bus_req[(ptr + k) % N]) cur = (ptr + k) % N;
                  end
                  l_we       = bus_we[cur];
                  l_addr     = bus_addr[cur*AW +: AW];
                  l_wdata    = bus_wdata[cur*DW +: DW];
                  acc_n      = 0;
                  long_stall = ($urandom_range(0, 7) == 0);
                  ph         = 1;
               end
            end
            1: begin
               acc_n++;
               mem_ready = long_stall ? 1'b0 : 1'($urandom_range(0, 2) != 0);
               if (mem_ready) begin
                  ph      = 2;
                  exp_err = 1'b0;
                  if (!l_we) rd_exp = mem_rdata;
               end else if (acc_n == TO) begin
                  ph      = 2;
                  exp_err = 1'b1;
               end
            end
            default: ph = 0;
         endcase
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b0;
      bus_req   = '0;
      bus_we    = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
